reg_writeback: RTL



---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 67 ++++++
 rtl/reg_writeback.sv | 105 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register write-back path:
// default widths and the queued write entry.
package wb_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 3;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write queue with per-entry read-out
// in age order (index 0 = oldest) for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  wb_entry_t                i_din,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [DEPTH-1:0]         o_vld,
  output wb_entry_t [DEPTH-1:0]    o_ent
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity comes from r_count.
  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_comb begin
    o_vld = '0;
    o_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent[i] = r_mem[r_rd_ptr + PW'(i)];
      o_vld[i] = CW'(i) < r_count;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;

endmodule

// File: rtl/reg_writeback.sv
// Register-file write side: queues retiring results,
// drains one per cycle and forwards pending values.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic              regwrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [7:0]        retire_cnt
);

  wb_entry_t              w_din;
  wb_entry_t              w_head;
  wb_entry_t [DEPTH-1:0]  w_ent;
  logic [DEPTH-1:0]       w_vld;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_hit;
  logic [DATA_W-1:0]      w_fdata;

  logic              r_regwrite;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [7:0]        r_retire_cnt;

  // A full queue always has a head, so drain_en alone decides the pop.
  assign w_pop    = !w_empty && drain_en;
  assign in_ready = !w_full || drain_en;
  assign w_push   = in_valid && in_ready && in_wen;

  assign w_din.rd   = in_rd;
  assign w_din.data = in_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_vld   (w_vld),
    .o_ent   (w_ent)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_regwrite <= w_pop;
      if (w_pop) begin
        r_write_reg  <= w_head.rd;
        r_write_data <= w_head.data;
        r_retire_cnt <= r_retire_cnt + 8'd1;
      end
    end
  end

  // Oldest-to-youngest scan; later matches override earlier ones.
  always_comb begin
    w_hit   = r_regwrite && (r_write_reg == fwd_rs);
    w_fdata = w_hit ? r_write_data : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i] && (w_ent[i].rd == fwd_rs)) begin
        w_hit   = 1'b1;
        w_fdata = w_ent[i].data;
      end
    end
  end

  assign regwrite   = r_regwrite;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign retire_cnt = r_retire_cnt;
  assign fwd_hit    = w_hit;
  assign fwd_data   = w_fdata;

  // w_count is kept for visibility in waveforms only.
  logic w_unused;
  assign w_unused = ^w_count;

endmodule
